// File: rtl/serial_pkg.sv
// serial_pkg: types and helpers shared by the serial operand loader and
// the downstream result collector.
//   loader_state_t : loader FSM state encoding
//   cnt_w()        : bit-counter width for a given operand width
package serial_pkg;

  typedef enum logic {IDLE, SHIFT} loader_state_t;

  // Never returns 0, so a counter declared from it always has at least one bit.
  function automatic int cnt_w(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/piso_shift_reg.sv
// piso_shift_reg: WIDTH-bit parallel-in / serial-out shift register.
// Shifts right with zero fill, so dout always carries the current LSB.
//   clk, reset : clock, synchronous active-high reset
//   clr        : synchronous clear (takes priority over load/shift)
//   load, din  : parallel load
//   shift      : shift right by one
//   dout       : current LSB
module piso_shift_reg #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             dout
);

  logic [WIDTH-1:0] sr;

  always_ff @(posedge clk) begin
    if (reset || clr) sr <= '0;
    else if (load)    sr <= din;
    else if (shift)   sr <= {1'b0, sr[WIDTH-1:1]};
  end

  assign dout = sr[0];

endmodule

// File: rtl/serial_operand_loader.sv
// serial_operand_loader: accepts a pair of WIDTH-bit operands over
// valid/ready and streams them LSB-first, one bit pair per beat, with
// first/last framing for a bit-serial adder.
// Optional feature macro: SERIAL_LOADER_SUB_EN (adds 'sub' port; the B
// stream is inverted and carry-in is 1 on the first beat, giving A-B).
//   clk, reset          : clock, synchronous active-high reset
//   in_valid/in_ready   : operand handshake; in_a, in_b parallel operands
//   out_valid/out_ready : bit-pair handshake
//   out_a, out_b        : current bit pair
//   out_first/out_last  : beat is bit 0 / bit WIDTH-1
//   out_cin             : carry-in the adder loads on the first beat
//   busy                : word in flight
module serial_operand_loader
  import serial_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
`ifdef SERIAL_LOADER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_a,
  output logic             out_b,
  output logic             out_first,
  output logic             out_last,
  output logic             out_cin,
  output logic             busy
);

  localparam int CNT_W = cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

  loader_state_t state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic load, shift;

  // Operand lanes: 0 = A, 1 = B
  logic [1:0][WIDTH-1:0] opnd;
  logic [1:0]            lsb;

  assign opnd = {in_b, in_a};

  for (genvar g = 0; g < 2; g++) begin : g_sr
    piso_shift_reg #(.WIDTH(WIDTH)) u_sr (
      .clk   (clk),
      .reset (reset),
      .clr   (shift && out_last),
      .load  (load),
      .shift (shift),
      .din   (opnd[g]),
      .dout  (lsb[g])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    load      = 1'b0;
    shift     = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          load      = 1'b1;
          cnt_nxt   = '0;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (out_ready) begin
          shift = 1'b1;
          if (cnt == LAST_IDX) begin
            cnt_nxt   = '0;
            state_nxt = IDLE;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef SERIAL_LOADER_SUB_EN
  logic sub_r;
  always_ff @(posedge clk) begin
    if (reset)     sub_r <= 1'b0;
    else if (load) sub_r <= sub;
  end
`else
  logic sub_r;
  assign sub_r = 1'b0;
`endif

  // Everything below decodes registered state only; data outputs are
  // gated so they read 0 whenever no beat is offered.
  assign in_ready  = (state == IDLE);
  assign busy      = !in_ready;
  assign out_valid = (state == SHIFT);
  assign out_first = out_valid && (cnt == '0);
  assign out_last  = out_valid && (cnt == LAST_IDX);
  assign out_a     = out_valid && lsb[0];
  assign out_b     = out_valid && (lsb[1] ^ sub_r);
  assign out_cin   = out_first && sub_r;

endmodule

// File: doc/serial_operand_loader.md
Name: serial_operand_loader

Overview:
- Upstream feeder for the bit-serial adder datapath.
- Accepts two parallel WIDTH-bit operands over a valid/ready handshake and shifts them out LSB-first, one bit pair per accepted beat.
- Emits first/last framing so the downstream adder clears its carry flop on bit 0, and the result collector closes the word on bit WIDTH-1.
- Produces back-pressure upstream while a word is in flight.

Parameters:
- WIDTH, 3, operand width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH), bit-counter width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  operand pair on in_a/in_b is valid
- in_ready  output  1  loader can accept an operand pair
- in_a  input  WIDTH  operand A, parallel
- in_b  input  WIDTH  operand B, parallel
- out_valid  output  1  out_a/out_b/out_first/out_last/out_cin are valid
- out_ready  input  1  downstream consumes the current bit pair
- out_a  output  1  current bit of A (LSB-first)
- out_b  output  1  current bit of B (LSB-first)
- out_first  output  1  current beat is bit 0; downstream loads carry from out_cin
- out_last  output  1  current beat is bit WIDTH-1
- out_cin  output  1  carry-in for bit 0; 0 unless SERIAL_LOADER_SUB_EN is active
- busy  output  1  word in flight (state != IDLE)

Behaviour:
- Reset: synchronous, active-high, when reset is sampled high at a clk edge.
  - State = IDLE; shift registers and counter = 0.
  - in_ready=1; out_valid=0; out_a=out_b=out_first=out_last=out_cin=0; busy=0.
  - Applies mid-word: any partially shifted word is discarded with no out_last beat.
- FSM states: IDLE, SHIFT.
  - IDLE:
    - in_ready=1, out_valid=0.
    - On in_valid&&in_ready: latch in_a→a_sr and in_b→b_sr, cnt=0, go to SHIFT.
  - SHIFT:
    - in_ready=0, out_valid=1.
    - out_a=a_sr[0], out_b=b_sr[0].
    - out_first=(cnt==0), out_last=(cnt==WIDTH-1).
  - SHIFT, on out_valid&&out_ready:
    - a_sr and b_sr shift right with zero fill; cnt++.
    - If out_last, go to IDLE and clear cnt.
  - SHIFT, out_ready=0: all outputs held stable, no shift, no count (AXI-style: valid never drops without a handshake).
- Latency and throughput:
  - The first bit is presented the cycle after acceptance.
  - One word takes WIDTH handshaken beats plus one IDLE cycle.
  - Peak throughput is WIDTH+1 cycles per word; there is no same-cycle reload on the last beat.
- Outputs are registered or decoded from registered state only; no combinational path from in_* to out_*.
- in_valid while busy is ignored: not latched, no error.
- busy equals !in_ready.
- Counter wrap: cnt never exceeds WIDTH-1; it is cleared on exit from SHIFT.

Optional Feature:
- Macro: SERIAL_LOADER_SUB_EN.
- Defined:
  - Adds input port sub (1 bit), sampled together with the operands on acceptance into a sub_r flop.
  - While sub_r=1: out_b = ~b_sr[0], and out_cin=1 on the out_first beat (two's-complement A−B).
  - out_cin=0 on all other beats.
- Undefined:
  - No sub port and no sub_r flop.
  - out_b = b_sr[0]; out_cin is tied to 0.

Decomposition:
- Package serial_pkg:
  - typedef enum {IDLE, SHIFT} loader_state_t.
  - Localparam helpers for counter width.
  - Shared with the downstream result collector.
- One natural sub-module: piso_shift_reg (WIDTH-bit parallel-load, shift-right-on-enable, zero-fill, synchronous clear), instantiated twice, for A and B.
- FSM and counter stay in the top.

Test Plan:
- Reset check: reset high 2 cycles → in_ready=1, out_valid=0, busy=0, all data outputs 0.
- Basic word, WIDTH=3: in_a=3'b101, in_b=3'b011, out_ready=1 → beats (a,b) = (1,1),(0,1),(1,0); out_first on beat 0 only; out_last on beat 2 only; in_ready high again the cycle after the last beat.
- Back-pressure: same word with out_ready low for 3 cycles after beat 1 → out_a=0, out_b=1 held stable with out_valid=1; the sequence resumes unchanged.
- Busy ignore: pulse in_valid with in_a=3'b111 during SHIFT → no effect; after completion, the original word's bits were emitted exactly.
- Reset mid-word: assert reset after beat 1 → next cycle IDLE, out_valid=0; a new word 3'b110/3'b001 then emits (0,1),(1,0),(1,0).
- SERIAL_LOADER_SUB_EN with sub=1, in_a=3'b101, in_b=3'b011 → out_b sequence 0,0,1; out_cin=1 on the first beat only; a downstream adder yields 3'b010.
